dmem_stage_nlane: RTL and testbench

Parametrised, N-lane data-memory pipeline stage for the superscalar core. It generalises the fixed two-lane memory stage to NUM_LANES issue lanes and configurable width and depth, using posedge-only timing. It adds intra-bundle write ordering, same-cycle store-to-load forwarding, per-lane external (main-core) write override, and range checking with a sticky error flag. It sits between EX and WB and passes pc, inst and per-lane destination registers through alongside the read data.

---
 rtl/dmem_stage_nlane.sv | 169 ++++++++++++++++
 tb/tb_dmem_stage_nlane.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_stage_nlane.sv
// N-lane data-memory stage: S1 captures the bundle and accesses memory, the output
// stage registers read data and pass-through fields (2-cycle latency).
module dmem_stage_nlane #(
    parameter int unsigned NUM_LANES = 2,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 17,
    parameter int unsigned DEPTH     = 131072,
    parameter int unsigned INST_W    = 64
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        interlock,
    input  logic [31:0]                 pc,
    input  logic [INST_W-1:0]           inst,
    input  logic [NUM_LANES*32-1:0]     lane_addr,
    input  logic [NUM_LANES*DATA_W-1:0] lane_din,
    input  logic [NUM_LANES-1:0]        lane_we,
    input  logic [NUM_LANES-1:0]        lane_re,
    input  logic [NUM_LANES*5-1:0]      lane_rt,
    input  logic [NUM_LANES-1:0]        ext_we,
    input  logic [NUM_LANES*ADDR_W-1:0] ext_addr,
    input  logic [NUM_LANES*DATA_W-1:0] ext_din,
    output logic [31:0]                 pc_out,
    output logic [INST_W-1:0]           inst_out,
    output logic [NUM_LANES*5-1:0]      rt_out,
    output logic [NUM_LANES*DATA_W-1:0] dout,
    output logic [NUM_LANES-1:0]        dout_valid,
    output logic                        range_err
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0]           r_mem [DEPTH];

    logic [ADDR_W-1:0]           r_s1_addr [NUM_LANES];
    logic [DATA_W-1:0]           r_s1_din  [NUM_LANES];
    logic [NUM_LANES-1:0]        r_s1_we;
    logic [NUM_LANES-1:0]        r_s1_re;
    logic [NUM_LANES*5-1:0]      r_s1_rt;
    logic [31:0]                 r_s1_pc;
    logic [INST_W-1:0]           r_s1_inst;

    logic [31:0]                 r_pc_out;
    logic [INST_W-1:0]           r_inst_out;
    logic [NUM_LANES*5-1:0]      r_rt_out;
    logic [NUM_LANES*DATA_W-1:0] r_dout;
    logic [NUM_LANES-1:0]        r_dout_valid;
    logic                        r_range_err;

    logic [ADDR_W-1:0]           w_ext_addr [NUM_LANES];
    logic [DATA_W-1:0]           w_ext_din  [NUM_LANES];
    logic [NUM_LANES-1:0]        w_ext_inr;
    logic [NUM_LANES-1:0]        w_lane_inr;
    logic [NUM_LANES-1:0]        w_ext_commit;
    logic [NUM_LANES-1:0]        w_lane_commit;
    logic [NUM_LANES*DATA_W-1:0] w_rd_flat;
    logic                        w_err_hit;
    logic                        w_unused_addr;

    // Only the word-address field of each lane address is consumed.
    assign w_unused_addr = ^lane_addr;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 64'(a) < 64'(DEPTH);
    endfunction

    always_comb begin
        w_ext_inr     = '0;
        w_lane_inr    = '0;
        w_ext_commit  = '0;
        w_lane_commit = '0;
        w_err_hit     = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_ext_addr[i]    = ext_addr[i*ADDR_W +: ADDR_W];
            w_ext_din[i]     = ext_din[i*DATA_W +: DATA_W];
            w_ext_inr[i]     = in_range(w_ext_addr[i]);
            w_lane_inr[i]    = in_range(r_s1_addr[i]);
            w_ext_commit[i]  = ext_we[i] & w_ext_inr[i];
            // An ext write owns its slot even when it is dropped for being out of range.
            w_lane_commit[i] = r_s1_we[i] & ~ext_we[i] & ~interlock & rstn & w_lane_inr[i];
            if (ext_we[i] && !w_ext_inr[i]) begin
                w_err_hit = 1'b1;
            end
            if ((r_s1_we[i] || r_s1_re[i]) && !w_lane_inr[i] && !interlock) begin
                w_err_hit = 1'b1;
            end
        end
    end

    always_comb begin
        w_rd_flat = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (r_s1_re[i] && w_lane_inr[i]) begin
                w_rd_flat[i*DATA_W +: DATA_W] = r_mem[r_s1_addr[i][IDX_W-1:0]];
                // Write-first: later slots override earlier, ext overrides lane in a slot.
                for (int j = 0; j < NUM_LANES; j++) begin
                    if (w_lane_commit[j] && (r_s1_addr[j] == r_s1_addr[i])) begin
                        w_rd_flat[i*DATA_W +: DATA_W] = r_s1_din[j];
                    end
                    if (w_ext_commit[j] && (w_ext_addr[j] == r_s1_addr[i])) begin
                        w_rd_flat[i*DATA_W +: DATA_W] = w_ext_din[j];
                    end
                end
            end
        end
    end

    // Ascending slot order makes the highest slot the last assignment, so it wins.
    always_ff @(posedge clk) begin
        for (int j = 0; j < NUM_LANES; j++) begin
            if (w_lane_commit[j]) begin
                r_mem[r_s1_addr[j][IDX_W-1:0]] <= r_s1_din[j];
            end
            if (w_ext_commit[j]) begin
                r_mem[w_ext_addr[j][IDX_W-1:0]] <= w_ext_din[j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                r_s1_addr[i] <= '0;
                r_s1_din[i]  <= '0;
            end
            r_s1_we      <= '0;
            r_s1_re      <= '0;
            r_s1_rt      <= '0;
            r_s1_pc      <= '0;
            r_s1_inst    <= '0;
            r_pc_out     <= '0;
            r_inst_out   <= '0;
            r_rt_out     <= '0;
            r_dout       <= '0;
            r_dout_valid <= '0;
        end else if (!interlock) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                r_s1_addr[i] <= lane_addr[i*32+2 +: ADDR_W];
                r_s1_din[i]  <= lane_din[i*DATA_W +: DATA_W];
            end
            r_s1_we      <= lane_we;
            r_s1_re      <= lane_re;
            r_s1_rt      <= lane_rt;
            r_s1_pc      <= pc;
            r_s1_inst    <= inst;
            r_pc_out     <= r_s1_pc;
            r_inst_out   <= r_s1_inst;
            r_rt_out     <= r_s1_rt;
            r_dout       <= w_rd_flat;
            r_dout_valid <= r_s1_re;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_range_err <= 1'b0;
        end else if (w_err_hit) begin
            r_range_err <= 1'b1;
        end
    end

    assign pc_out     = r_pc_out;
    assign inst_out   = r_inst_out;
    assign rt_out     = r_rt_out;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign range_err  = r_range_err;

endmodule

// File: tb/tb_dmem_stage_nlane.sv
// Bench for dmem_stage_nlane: directed scenarios plus a randomized run checked against a
// bundle-level model (memory as an associative array, one held bundle, expected outputs).
module tb_dmem_stage_nlane;
    localparam int NL    = 2;
    localparam int DW    = 32;
    localparam int AW    = 18;
    localparam int DEPTH = 4096;
    localparam int IW    = 64;

    logic              clk = 1'b0;
    logic              rstn;
    logic              interlock;
    logic [31:0]       pc;
    logic [IW-1:0]     inst;
    logic [NL*32-1:0]  lane_addr;
    logic [NL*DW-1:0]  lane_din;
    logic [NL-1:0]     lane_we;
    logic [NL-1:0]     lane_re;
    logic [NL*5-1:0]   lane_rt;
    logic [NL-1:0]     ext_we;
    logic [NL*AW-1:0]  ext_addr;
    logic [NL*DW-1:0]  ext_din;
    logic [31:0]       pc_out;
    logic [IW-1:0]     inst_out;
    logic [NL*5-1:0]   rt_out;
    logic [NL*DW-1:0]  dout;
    logic [NL-1:0]     dout_valid;
    logic              range_err;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_stage_nlane #(
        .NUM_LANES(NL), .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .INST_W(IW)
    ) dut (
        .clk(clk), .rstn(rstn), .interlock(interlock), .pc(pc), .inst(inst),
        .lane_addr(lane_addr), .lane_din(lane_din), .lane_we(lane_we), .lane_re(lane_re),
        .lane_rt(lane_rt), .ext_we(ext_we), .ext_addr(ext_addr), .ext_din(ext_din),
        .pc_out(pc_out), .inst_out(inst_out), .rt_out(rt_out), .dout(dout),
        .dout_valid(dout_valid), .range_err(range_err)
    );

    always #5 clk = ~clk;

    // Model: memory, the bundle held in the stage, and the expected output bundle.
    logic [DW-1:0]   m_mem [int];
    int              m_s_addr [NL];
    logic [DW-1:0]   m_s_din [NL];
    logic [NL-1:0]   m_s_we, m_s_re;
    logic [NL*5-1:0] m_s_rt;
    logic [31:0]     m_s_pc;
    logic [IW-1:0]   m_s_inst;
    logic [DW-1:0]   e_dout [NL];
    bit              e_known [NL];
    logic [NL-1:0]   e_valid;
    logic [NL*5-1:0] e_rt;
    logic [31:0]     e_pc;
    logic [IW-1:0]   e_inst;
    logic            e_err;

    // Advance the model by one edge using the current inputs, then clock the DUT.
    task automatic tick();
        bit hit;
        int ea;
        hit = 1'b0;
        for (int j = 0; j < NL; j++) begin
            ea = int'(ext_addr[j*AW +: AW]);
            if (ext_we[j]) begin
                if (ea < DEPTH) m_mem[ea] = ext_din[j*DW +: DW];
                else hit = 1'b1;
            end else if (m_s_we[j] && !interlock && rstn && m_s_addr[j] < DEPTH) begin
                m_mem[m_s_addr[j]] = m_s_din[j];
            end
        end
        if (!rstn) begin
            for (int i = 0; i < NL; i++) begin
                m_s_addr[i] = 0; m_s_din[i] = '0; e_dout[i] = '0; e_known[i] = 1'b1;
            end
            m_s_we = '0; m_s_re = '0; m_s_rt = '0; m_s_pc = '0; m_s_inst = '0;
            e_valid = '0; e_rt = '0; e_pc = '0; e_inst = '0; e_err = 1'b0;
        end else begin
            if (!interlock) begin
                for (int i = 0; i < NL; i++) begin
                    e_dout[i] = '0;
                    e_known[i] = 1'b1;
                    if ((m_s_we[i] || m_s_re[i]) && m_s_addr[i] >= DEPTH) hit = 1'b1;
                    if (m_s_re[i] && m_s_addr[i] < DEPTH) begin
                        e_known[i] = m_mem.exists(m_s_addr[i]);
                        if (e_known[i]) e_dout[i] = m_mem[m_s_addr[i]];
                    end
                end
                e_valid = m_s_re; e_rt = m_s_rt; e_pc = m_s_pc; e_inst = m_s_inst;
                for (int i = 0; i < NL; i++) begin
                    m_s_addr[i] = int'(lane_addr[i*32+2 +: AW]);
                    m_s_din[i]  = lane_din[i*DW +: DW];
                end
                m_s_we = lane_we; m_s_re = lane_re; m_s_rt = lane_rt;
                m_s_pc = pc; m_s_inst = inst;
            end
            if (hit) e_err = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        interlock = 1'b0; pc = '0; inst = '0;
        lane_addr = '0; lane_din = '0; lane_we = '0; lane_re = '0; lane_rt = '0;
        ext_we = '0; ext_addr = '0; ext_din = '0;
    endtask

    task automatic set_lane(input int l, input logic [31:0] a, input logic [DW-1:0] d,
                            input logic we, input logic re, input logic [4:0] rt);
        lane_addr[l*32 +: 32] = a;
        lane_din[l*DW +: DW]  = d;
        lane_we[l] = we;
        lane_re[l] = re;
        lane_rt[l*5 +: 5] = rt;
    endtask

    task automatic set_ext(input int l, input int w, input logic [DW-1:0] d);
        ext_we[l] = 1'b1;
        ext_addr[l*AW +: AW] = w[AW-1:0];
        ext_din[l*DW +: DW] = d;
    endtask

    task automatic test_reset();
        idle(); rstn = 1'b0;
        tick(); tick();
        n_tests++;
        if ({pc_out, inst_out, rt_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_passthru: got pc=%h inst=%h rt=%h want 0", pc_out, inst_out, rt_out);
        end
        n_tests++;
        if ({dout, dout_valid} !== '0) begin
            n_fail++; $display("FAIL reset_dout: got dout=%h valid=%b want 0", dout, dout_valid);
        end
        n_tests++;
        if (range_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_err: got %b want 0", range_err);
        end
        rstn = 1'b1;
        set_ext(0, 'h30, 32'hCAFE0001); tick(); idle();
        rstn = 1'b0; tick(); tick(); rstn = 1'b1;
        set_lane(0, 32'h0C0, '0, 1'b0, 1'b1, 5'd3); tick(); idle(); tick();
        n_tests++;
        if (dout[31:0] !== 32'hCAFE0001 || dout_valid !== 2'b01 || rt_out[4:0] !== 5'd3) begin
            n_fail++;
            $display("FAIL reset_retain: got dout=%h valid=%b rt=%0d want cafe0001 01 3",
                     dout[31:0], dout_valid, rt_out[4:0]);
        end
    endtask

    task automatic test_store_load();
        idle(); pc = 32'h1000;
        set_lane(0, 32'h100, 32'hDEADBEEF, 1'b1, 1'b0, 5'd1); tick();
        idle(); pc = 32'h1004;
        set_lane(0, 32'h100, '0, 1'b0, 1'b1, 5'd2); tick();
        idle(); tick();
        n_tests++;
        if (dout[31:0] !== 32'hDEADBEEF || dout_valid !== 2'b01) begin
            n_fail++; $display("FAIL store_load_data: got %h valid=%b want deadbeef 01",
                               dout[31:0], dout_valid);
        end
        n_tests++;
        if (pc_out !== 32'h1004 || rt_out[4:0] !== 5'd2) begin
            n_fail++; $display("FAIL store_load_pc: got pc=%h rt=%0d want 1004 2", pc_out, rt_out[4:0]);
        end
    endtask

    task automatic test_same_bundle();
        idle();
        set_lane(0, 32'h40, 32'h11, 1'b1, 1'b1, 5'd1);
        set_lane(1, 32'h40, 32'h22, 1'b1, 1'b1, 5'd2);
        tick(); idle(); tick();
        n_tests++;
        if (dout !== {32'h22, 32'h22} || dout_valid !== 2'b11) begin
            n_fail++; $display("FAIL same_bundle_fwd: got %h valid=%b want 22/22 11", dout, dout_valid);
        end
        set_lane(0, 32'h40, '0, 1'b0, 1'b1, 5'd0); tick(); idle(); tick();
        n_tests++;
        if (dout[31:0] !== 32'h22) begin
            n_fail++; $display("FAIL same_bundle_mem: got %h want 22", dout[31:0]);
        end
    endtask

    task automatic test_ext_override();
        idle();
        set_lane(0, 32'h40, 32'h66, 1'b1, 1'b0, 5'd0);
        set_lane(1, 32'h40, '0, 1'b0, 1'b1, 5'd5);
        tick(); idle(); set_ext(0, 'h10, 32'h55); tick(); idle();
        n_tests++;
        if (dout[63:32] !== 32'h55 || dout_valid !== 2'b10) begin
            n_fail++; $display("FAIL ext_fwd: got %h valid=%b want 55 10", dout[63:32], dout_valid);
        end
        set_lane(0, 32'h40, '0, 1'b0, 1'b1, 5'd0); tick(); idle(); tick();
        n_tests++;
        if (dout[31:0] !== 32'h55) begin
            n_fail++; $display("FAIL ext_mem: got %h want 55", dout[31:0]);
        end
    endtask

    task automatic test_interlock();
        idle(); pc = 32'h1FFC; tick();
        set_lane(0, 32'h200, 32'hA5, 1'b1, 1'b0, 5'd4);
        set_lane(1, 32'h200, '0, 1'b0, 1'b1, 5'd7);
        pc = 32'h2000; tick();
        interlock = 1'b1; pc = 32'h3000;
        set_lane(0, 32'h300, 32'hBAD, 1'b1, 1'b1, 5'd9);
        set_ext(0, 'h20, 32'h77); tick();
        ext_we = '0; tick(); tick();
        n_tests++;
        if (pc_out !== 32'h1FFC || dout_valid !== 2'b00) begin
            n_fail++; $display("FAIL interlock_freeze: got pc=%h valid=%b want 1ffc 00", pc_out, dout_valid);
        end
        idle(); tick();
        n_tests++;
        if (dout[63:32] !== 32'hA5 || dout_valid !== 2'b10 || pc_out !== 32'h2000 ||
            rt_out[9:5] !== 5'd7) begin
            n_fail++; $display("FAIL interlock_release: got d=%h v=%b pc=%h rt=%0d want a5 10 2000 7",
                               dout[63:32], dout_valid, pc_out, rt_out[9:5]);
        end
        set_lane(0, 32'h80, '0, 1'b0, 1'b1, 5'd0);
        set_lane(1, 32'h200, '0, 1'b0, 1'b1, 5'd0);
        tick(); idle(); tick();
        n_tests++;
        if (dout !== {32'hA5, 32'h77}) begin
            n_fail++; $display("FAIL interlock_mem: got %h want a5/77", dout);
        end
    endtask

    task automatic test_range();
        idle(); set_ext(0, 0, 32'h12345678); tick(); idle();
        n_tests++;
        if (range_err !== 1'b0) begin
            n_fail++; $display("FAIL range_pre: got %b want 0", range_err);
        end
        set_lane(0, 32'h80000, '0, 1'b0, 1'b1, 5'd0);
        set_lane(1, 32'h4000, 32'hBADBAD, 1'b1, 1'b0, 5'd0);
        tick(); idle(); tick();
        n_tests++;
        if (dout[31:0] !== '0 || dout_valid[0] !== 1'b1 || range_err !== 1'b1) begin
            n_fail++; $display("FAIL range_oor: got d=%h v=%b err=%b want 0 1 1",
                               dout[31:0], dout_valid[0], range_err);
        end
        set_lane(0, 32'h0, '0, 1'b0, 1'b1, 5'd0);
        set_lane(1, 32'h100, '0, 1'b0, 1'b1, 5'd0);
        tick(); idle(); tick();
        n_tests++;
        if (dout !== {32'hDEADBEEF, 32'h12345678} || range_err !== 1'b1) begin
            n_fail++; $display("FAIL range_after: got %h err=%b want deadbeef/12345678 1", dout, range_err);
        end
        rstn = 1'b0; tick(); rstn = 1'b1;
        n_tests++;
        if (range_err !== 1'b0) begin
            n_fail++; $display("FAIL range_reset: got %b want 0", range_err);
        end
        set_ext(1, DEPTH, 32'h99); tick(); idle();
        n_tests++;
        if (range_err !== 1'b1) begin
            n_fail++; $display("FAIL range_ext: got %b want 1", range_err);
        end
    endtask

    task automatic test_random();
        int w;
        logic [31:0] a;
        idle(); rstn = 1'b0; tick(); rstn = 1'b1;
        for (int c = 0; c < 600; c++) begin
            rstn = ($urandom_range(0, 63) != 0);
            interlock = ($urandom_range(0, 4) == 0);
            pc = $urandom;
            inst = {$urandom, $urandom};
            ext_we = '0;
            for (int l = 0; l < NL; l++) begin
                w = $urandom_range(0, 7);
                if ($urandom_range(0, 15) == 0) w = DEPTH + $urandom_range(0, 3);
                a = $urandom;
                a[AW+1:2] = w[AW-1:0];
                set_lane(l, a, $urandom, 1'($urandom), 1'($urandom), 5'($urandom));
                if ($urandom_range(0, 3) == 0) begin
                    w = $urandom_range(0, 7);
                    if ($urandom_range(0, 15) == 0) w = DEPTH + $urandom_range(0, 3);
                    set_ext(l, w, $urandom);
                end
            end
            tick();
            for (int l = 0; l < NL; l++) begin
                n_tests++;
                if (dout_valid[l] !== e_valid[l]) begin
                    n_fail++; $display("FAIL rand_valid[%0d] c=%0d: got %b want %b",
                                       l, c, dout_valid[l], e_valid[l]);
                end
                if (e_valid[l] && e_known[l]) begin
                    n_tests++;
                    if (dout[l*DW +: DW] !== e_dout[l]) begin
                        n_fail++; $display("FAIL rand_dout[%0d] c=%0d: got %h want %h",
                                           l, c, dout[l*DW +: DW], e_dout[l]);
                    end
                end
            end
            n_tests++;
            if ({pc_out, inst_out, rt_out} !== {e_pc, e_inst, e_rt}) begin
                n_fail++; $display("FAIL rand_passthru c=%0d: got %h/%h/%h want %h/%h/%h",
                                   c, pc_out, inst_out, rt_out, e_pc, e_inst, e_rt);
            end
            n_tests++;
            if (range_err !== e_err) begin
                n_fail++; $display("FAIL rand_err c=%0d: got %b want %b", c, range_err, e_err);
            end
        end
        idle(); rstn = 1'b1;
    endtask

    initial begin
        idle();
        rstn = 1'b0;
        test_reset();
        test_store_load();
        test_same_bundle();
        test_ext_override();
        test_interlock();
        test_range();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
